// File: rtl/pipeline_commit_checker.sv
// pipeline_commit_checker: sequences the datapath reset, then checks every writeback
// commit against a loadable table of expected (rd, data) pairs with a cycle budget.
module pipeline_commit_checker #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 16,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_addr,
    input  logic [4:0]               exp_rd,
    input  logic [XLEN-1:0]          exp_data,
    input  logic [$clog2(DEPTH):0]   exp_count,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     dut_reset,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [$clog2(DEPTH)-1:0] fail_index,
    output logic [XLEN-1:0]          fail_data,
    output logic [$clog2(DEPTH):0]   commit_count,
    output logic [31:0]              cycle_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(RESET_CYCLES) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] target_q, target_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] commit_q, commit_d;
    logic [31:0] cycle_q, cycle_d;
    logic [AW-1:0] fail_index_q, fail_index_d;
    logic [XLEN-1:0] fail_data_q, fail_data_d;
    logic [4:0] tbl_rd_q [DEPTH];
    logic [XLEN-1:0] tbl_data_q [DEPTH];
    logic [4:0] cur_rd;
    logic [XLEN-1:0] cur_data;
    logic commit, match, final_match, restart;

    // Table has no reset; it survives both reset and restarts.
    always_ff @(posedge clk)
        if (state_q == S_IDLE && exp_we) begin
            tbl_rd_q[exp_addr] <= exp_rd;
            tbl_data_q[exp_addr] <= exp_data;
        end

    always_comb begin
        cur_rd = tbl_rd_q[commit_q[AW-1:0]];
        cur_data = tbl_data_q[commit_q[AW-1:0]];
        commit = wb_valid && wb_rd != 5'd0;
        match = cur_rd == wb_rd && cur_data == wb_data;
        final_match = commit && match && (commit_q + CW'(1)) == target_q;
        restart = start && (state_q == S_IDLE || done);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= S_IDLE;
            target_q <= '0;
            hold_q <= '0;
            commit_q <= '0;
            cycle_q <= '0;
            fail_index_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q <= state_d;
            target_q <= target_d;
            hold_q <= hold_d;
            commit_q <= commit_d;
            cycle_q <= cycle_d;
            fail_index_q <= fail_index_d;
            fail_data_q <= fail_data_d;
        end

    // Mismatch beats final match, which beats timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_PASS, S_FAIL, S_TMO: state_d = start ? S_HOLD : state_q;
            S_HOLD: state_d = hold_q != HOLD_LAST ? S_HOLD : target_q == '0 ? S_PASS : S_RUN;
            S_RUN: state_d = commit && !match ? S_FAIL : final_match ? S_PASS :
                             cycle_q == TIMEOUT_LAST ? S_TMO : S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        target_d = target_q;
        hold_d = hold_q;
        commit_d = commit_q;
        cycle_d = cycle_q;
        fail_index_d = fail_index_q;
        fail_data_d = fail_data_q;
        if (restart) begin
            target_d = exp_count > DEPTH_C ? DEPTH_C : exp_count;
            hold_d = '0;
            commit_d = '0;
            cycle_d = '0;
            fail_index_d = '0;
            fail_data_d = '0;
        end
        if (state_q == S_HOLD)
            hold_d = hold_q + HW'(1);
        if (state_q == S_RUN) begin
            cycle_d = cycle_q + 32'd1;
            commit_d = commit && match ? commit_q + CW'(1) : commit_q;
            fail_index_d = commit && !match ? commit_q[AW-1:0] : fail_index_q;
            fail_data_d = commit && !match ? wb_data : fail_data_q;
        end
    end

    always_comb begin
        dut_reset = state_q != S_RUN;
        busy = state_q == S_HOLD || state_q == S_RUN;
        done = state_q == S_PASS || state_q == S_FAIL || state_q == S_TMO;
        pass = state_q == S_PASS;
    end

    assign fail_index = fail_index_q;
    assign fail_data = fail_data_q;
    assign commit_count = commit_q;
    assign cycle_count = cycle_q;
endmodule

// File: tb/tb_pipeline_commit_checker.sv
// tb_pipeline_commit_checker: directed and randomized commit streams checked against
// an outcome model that walks the stream with the checker's rules.
module tb_pipeline_commit_checker;
    localparam int DEPTH = 16;
    localparam int RC = 3;
    localparam int TMO = 20;

    logic clk = 0, reset = 1, start = 0, exp_we = 0, wb_valid = 0;
    logic [3:0] exp_addr = 0;
    logic [4:0] exp_rd = 0, exp_count = 0, wb_rd = 0;
    logic [31:0] exp_data = 0, wb_data = 0;
    logic dut_reset, busy, done, pass;
    logic [3:0] fail_index;
    logic [31:0] fail_data, cycle_count;
    logic [4:0] commit_count;

    int n_checks = 0, n_fail = 0;
    logic [4:0] m_rd [DEPTH];
    logic [31:0] m_data [DEPTH];
    logic ev_v [TMO];
    logic [4:0] ev_rd [TMO];
    logic [31:0] ev_data [TMO];

    pipeline_commit_checker #(.XLEN(32), .DEPTH(DEPTH), .RESET_CYCLES(RC), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_rd(exp_rd), .exp_data(exp_data), .exp_count(exp_count), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .dut_reset(dut_reset), .busy(busy), .done(done),
        .pass(pass), .fail_index(fail_index), .fail_data(fail_data),
        .commit_count(commit_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task go_idle;
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task load(input int a, input logic [4:0] rd, input logic [31:0] d);
        exp_we = 1; exp_addr = 4'(a); exp_rd = rd; exp_data = d;
        m_rd[a] = rd; m_data[a] = d;
        @(negedge clk);
        exp_we = 0;
    endtask

    task clear_ev;
        for (int t = 0; t < TMO; t++) begin
            ev_v[t] = 0; ev_rd[t] = 5'($urandom); ev_data[t] = $urandom;
        end
    endtask

    task set_ev(input int t, input logic [4:0] rd, input logic [31:0] d);
        ev_v[t] = 1; ev_rd[t] = rd; ev_data[t] = d;
    endtask

    // Predicts the outcome from the table mirror and event list, then drives and checks every cycle.
    task run_check(input int cnt, input string name);
        int eff, k, res, t_end;
        int cc_at [TMO];
        logic [3:0] fi;
        logic [31:0] fd;
        eff = cnt > DEPTH ? DEPTH : cnt;
        k = 0; res = 2; t_end = TMO - 1; fi = 0; fd = 0;
        for (int t = 0; t < TMO; t++) cc_at[t] = 0;
        if (eff == 0) begin
            res = 0; t_end = -1;
        end else begin
            for (int t = 0; t < TMO; t++) begin
                cc_at[t] = k;
                if (ev_v[t] && ev_rd[t] != 0) begin
                    if (ev_rd[t] == m_rd[k] && ev_data[t] == m_data[k]) begin
                        k++;
                        if (k == eff) begin res = 0; t_end = t; break; end
                    end else begin
                        res = 1; fi = 4'(k); fd = ev_data[t]; t_end = t; break;
                    end
                end
            end
        end
        exp_count = 5'(cnt); start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < RC; i++) begin
            n_checks++;
            if ({dut_reset, busy, done, commit_count, cycle_count} !== {3'b110, 5'd0, 32'd0}) begin
                n_fail++;
                $display("FAIL %s hold%0d: rst/busy/done=%b%b%b cc=%0d cyc=%0d, want 110 0 0", name, i, dut_reset, busy, done, commit_count, cycle_count);
            end
            @(negedge clk);
        end
        for (int t = 0; t <= t_end; t++) begin
            n_checks++;
            if ({dut_reset, busy, done} !== 3'b010 || cycle_count !== 32'(t) || commit_count !== 5'(cc_at[t])) begin
                n_fail++;
                $display("FAIL %s run%0d: rst/busy/done=%b%b%b cyc=%0d cc=%0d, want 010 %0d %0d", name, t, dut_reset, busy, done, cycle_count, commit_count, t, cc_at[t]);
            end
            wb_valid = ev_v[t]; wb_rd = ev_rd[t]; wb_data = ev_data[t];
            @(negedge clk);
        end
        wb_valid = 0;
        n_checks++;
        if ({dut_reset, busy, done, pass} !== {3'b101, res == 0} || commit_count !== 5'(k) ||
            cycle_count !== 32'(t_end + 1) || fail_index !== fi || fail_data !== fd) begin
            n_fail++;
            $display("FAIL %s result: rst/busy/done/pass=%b%b%b%b cc=%0d cyc=%0d fi=%0d fd=%0h, want 101%b %0d %0d %0d %0h",
                     name, dut_reset, busy, done, pass, commit_count, cycle_count, fail_index, fail_data,
                     res == 0, k, t_end + 1, fi, fd);
        end
    endtask

    task test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dut_reset, busy, done, pass, fail_index, fail_data, commit_count, cycle_count} !== {4'b1000, 4'd0, 32'd0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset: rst/busy/done/pass=%b%b%b%b fi=%0d fd=%0h cc=%0d cyc=%0d, want 1000 and zeros", dut_reset, busy, done, pass, fail_index, fail_data, commit_count, cycle_count);
        end
        reset = 0;
        @(negedge clk);
        n_checks++;
        if ({dut_reset, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL idle_after_reset: rst/busy/done=%b%b%b, want 100", dut_reset, busy, done);
        end
    endtask

    task pass_events;
        clear_ev;
        set_ev(1, 5'd1, 32'd5);
        set_ev(2, 5'd0, 32'd99);
        set_ev(4, 5'd2, 32'd7);
        set_ev(7, 5'd3, 32'd12);
    endtask

    task test_pass;
        load(0, 5'd1, 32'd5);
        load(1, 5'd2, 32'd7);
        load(2, 5'd3, 32'd12);
        pass_events;
        run_check(3, "pass");
        n_checks++;
        if (pass !== 1'b1 || commit_count !== 5'd3 || cycle_count !== 32'd8) begin
            n_fail++;
            $display("FAIL pass_const: pass=%b cc=%0d cyc=%0d, want 1 3 8", pass, commit_count, cycle_count);
        end
    endtask

    task test_fail;
        clear_ev;
        set_ev(0, 5'd1, 32'd5);
        set_ev(2, 5'd2, 32'd8);
        run_check(3, "fail");
        n_checks++;
        if (pass !== 1'b0 || fail_index !== 4'd1 || fail_data !== 32'd8 || commit_count !== 5'd1) begin
            n_fail++;
            $display("FAIL fail_const: pass=%b fi=%0d fd=%0d cc=%0d, want 0 1 8 1", pass, fail_index, fail_data, commit_count);
        end
        wb_valid = 1; wb_rd = 5'd3; wb_data = 32'd12;
        @(negedge clk);
        wb_valid = 0;
        @(negedge clk);
        n_checks++;
        if ({done, pass, dut_reset} !== 3'b101 || fail_index !== 4'd1 || fail_data !== 32'd8 || commit_count !== 5'd1) begin
            n_fail++;
            $display("FAIL fail_hold: done/pass/rst=%b%b%b fi=%0d fd=%0d cc=%0d, want 101 1 8 1", done, pass, dut_reset, fail_index, fail_data, commit_count);
        end
    endtask

    task test_timeout;
        clear_ev;
        set_ev(3, 5'd1, 32'd5);
        run_check(2, "timeout");
        n_checks++;
        if ({done, pass} !== 2'b10 || commit_count !== 5'd1 || cycle_count !== 32'(TMO)) begin
            n_fail++;
            $display("FAIL timeout_const: done/pass=%b%b cc=%0d cyc=%0d, want 10 1 %0d", done, pass, commit_count, cycle_count, TMO);
        end
    endtask

    task test_reset_mid_run;
        exp_count = 5'd3; start = 1;
        @(negedge clk);
        start = 0;
        repeat (RC) @(negedge clk);
        wb_valid = 1; wb_rd = 5'd1; wb_data = 32'd5;
        @(negedge clk);
        wb_valid = 0;
        @(negedge clk);
        n_checks++;
        if (commit_count !== 5'd1 || dut_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_pre: cc=%0d rst=%b, want 1 0", commit_count, dut_reset);
        end
        reset = 1;
        #1;
        n_checks++;
        if ({dut_reset, busy, done, pass} !== 4'b1000 || commit_count !== 5'd0 || cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: rst/busy/done/pass=%b%b%b%b cc=%0d cyc=%0d, want 1000 0 0", dut_reset, busy, done, pass, commit_count, cycle_count);
        end
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        n_checks++;
        if ({dut_reset, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL midrun_idle: rst/busy/done=%b%b%b, want 100", dut_reset, busy, done);
        end
    endtask

    task test_restart;
        pass_events;
        run_check(3, "restart_first");
        exp_we = 1; exp_addr = 4'd0; exp_rd = 5'd9; exp_data = 32'd99;
        @(negedge clk);
        exp_we = 0;
        run_check(3, "restart_second");
    endtask

    task test_zero_clamp;
        go_idle;
        clear_ev;
        run_check(0, "zero_count");
        go_idle;
        for (int i = 0; i < DEPTH; i++) load(i, 5'($urandom_range(1, 31)), $urandom);
        for (int i = 0; i < DEPTH; i++) set_ev(i, m_rd[i], m_data[i]);
        run_check(DEPTH + 5, "clamp");
        n_checks++;
        if (pass !== 1'b1 || commit_count !== 5'(DEPTH)) begin
            n_fail++;
            $display("FAIL clamp_const: pass=%b cc=%0d, want 1 %0d", pass, commit_count, DEPTH);
        end
    endtask

    task test_same_cycle;
        clear_ev;
        set_ev(TMO - 1, m_rd[0], m_data[0] ^ 32'h10);
        run_check(1, "mismatch_vs_timeout");
        n_checks++;
        if ({done, pass} !== 2'b10 || fail_index !== 4'd0 || fail_data !== (m_data[0] ^ 32'h10)) begin
            n_fail++;
            $display("FAIL mismatch_vs_timeout_const: done/pass=%b%b fi=%0d fd=%0h", done, pass, fail_index, fail_data);
        end
        clear_ev;
        set_ev(TMO - 1, m_rd[0], m_data[0]);
        run_check(1, "match_vs_timeout");
        n_checks++;
        if ({done, pass} !== 2'b11 || commit_count !== 5'd1) begin
            n_fail++;
            $display("FAIL match_vs_timeout_const: done/pass=%b%b cc=%0d, want 11 1", done, pass, commit_count);
        end
    endtask

    task test_random;
        int gk, r;
        for (int it = 0; it < 30; it++) begin
            go_idle;
            for (int i = 0; i < 12; i++) load(i, 5'($urandom_range(1, 31)), 32'($urandom_range(0, 7)));
            gk = 0;
            for (int t = 0; t < TMO; t++) begin
                r = $urandom_range(0, 19);
                ev_v[t] = 0; ev_rd[t] = 5'($urandom); ev_data[t] = $urandom;
                if (r < 6) ev_v[t] = 0;
                else if (r < 8) set_ev(t, 5'd0, $urandom);
                else if (r == 8) set_ev(t, m_rd[gk % 12], m_data[gk % 12] ^ (32'd1 << $urandom_range(0, 31)));
                else if (r == 9) set_ev(t, m_rd[gk % 12] ^ 5'd4, m_data[gk % 12]);
                else begin
                    set_ev(t, m_rd[gk % 12], m_data[gk % 12]);
                    gk++;
                end
            end
            run_check($urandom_range(0, 12), "random");
        end
    endtask

    initial begin
        test_reset;
        test_pass;
        test_fail;
        test_timeout;
        test_reset_mid_run;
        test_restart;
        test_zero_clamp;
        test_same_cycle;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_commit_checker.md
# pipeline_commit_checker

Synthesizable self-checking harness that sits beside the pipelined datapath. It sequences the datapath's reset, observes the writeback port, and compares every register commit against a loadable table of expected (rd, data) pairs. It reports pass, first-failure details, or a cycle-budget timeout. It replaces fixed-delay testbench reset and waveform inspection with a parametrised, reusable checker usable in simulation and on FPGA.

## Interface
Parameters:
- XLEN, 32, writeback data width
- DEPTH, 16, expected-commit table entries (power of two, ≥2)
- RESET_CYCLES, 2, cycles dut_reset is held after start (≥1)
- TIMEOUT, 1024, maximum RUN cycles before timeout (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin (or restart) a check run; sampled in IDLE and terminal states only
- exp_we  in  1  write expected entry; honoured only in IDLE
- exp_addr  in  $clog2(DEPTH)  table index
- exp_rd  in  5  expected destination register
- exp_data  in  XLEN  expected write data
- exp_count  in  $clog2(DEPTH)+1  commits to check; sampled on start; values >DEPTH clamp to DEPTH
- wb_valid  in  1  datapath RegWrite at writeback stage
- wb_rd  in  5  writeback register address
- wb_data  in  XLEN  writeback data
- dut_reset  out  1  reset driven to the datapath
- busy  out  1  high in HOLD and RUN
- done  out  1  high in PASS, FAIL, TIMEOUT
- pass  out  1  high only in PASS
- fail_index  out  $clog2(DEPTH)  table index of first mismatch
- fail_data  out  XLEN  wb_data that mismatched
- commit_count  out  $clog2(DEPTH)+1  commits matched so far
- cycle_count  out  32  RUN cycles elapsed

## Operation
- States: IDLE, HOLD, RUN, PASS, FAIL, TIMEOUT.
- Reset values: state=IDLE; dut_reset=1; busy=done=pass=0; fail_index=0; fail_data=0; commit_count=0; cycle_count=0. Table contents are not reset.
- IDLE: exp_we writes {exp_rd, exp_data} to entry exp_addr. start → HOLD, latching the clamped exp_count and clearing commit_count, cycle_count, fail_index, and fail_data.
- HOLD: dut_reset=1 for exactly RESET_CYCLES cycles, then → RUN. If the latched count is 0, → PASS instead.
- RUN: dut_reset=0; cycle_count increments every cycle. A commit is wb_valid=1 with wb_rd≠0; x0 writes and wb_valid=0 are ignored.
  - Commit matches entry[commit_count] on both rd and data: commit_count+1. If the new value equals the latched count → PASS.
  - Commit mismatches on rd or data → FAIL, latching fail_index=commit_count and fail_data=wb_data.
  - cycle_count reaching TIMEOUT-1 without termination → TIMEOUT.
- Terminal states (PASS, FAIL, TIMEOUT): dut_reset=1 freezes the datapath; all result outputs hold. start → HOLD (restart with the current table). exp_we is ignored.
- exp_we outside IDLE is dropped, including exp_we during HOLD/RUN.
- Priority within one RUN cycle: mismatch > final match (PASS) > timeout.
- reset mid-run: immediate return to IDLE, dut_reset=1, counters cleared.

## Timing
- All outputs are registered; state changes on the rising clk edge after the qualifying input.
- start in IDLE at edge N: HOLD from N+1; dut_reset falls at edge N+RESET_CYCLES+1.
- Commit comparison uses inputs sampled at the edge. Result flags appear one cycle after the final or mismatching commit.
- cycle_count = 0 in the first RUN cycle. The TIMEOUT state is entered at the edge ending RUN cycle TIMEOUT-1.
- Back-to-back commits on consecutive cycles are each checked; there is no stall input.
- The table write takes effect the following cycle. Table read is combinational from commit_count.

## Test plan
- Load 3 entries {x1=5, x2=7, x3=12}, exp_count=3, start, then drive the matching commits with gaps and one x0 write → PASS, commit_count=3, dut_reset low for exactly the RUN span.
- Same table; second commit is x2=8 → FAIL, fail_index=1, fail_data=8, commit_count=1. A following x3 commit has no effect.
- TIMEOUT=20, exp_count=2, only one matching commit → TIMEOUT at RUN cycle 19, pass=0, commit_count=1.
- exp_count=0, start → HOLD for RESET_CYCLES, then PASS with no RUN cycles. exp_count=DEPTH+5 clamps to DEPTH.
- Mismatch and timeout in the same cycle → FAIL. Final match and timeout in the same cycle → PASS.
- Assert reset during RUN → IDLE next evaluation, dut_reset=1, counters 0. Restart from PASS via start → HOLD with counters cleared and the table reused.
